// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
//
// Direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. It sits upstream of the fetch-stage predictor, which
// loads the predicted target, hit flag and counter state every cycle.
// Resolved branches from execute write back through the update port, which
// both allocates new entries and trains existing ones. Lookup-hit and
// mispredict statistics are kept here as well.
//
// Parameters
//   ENTRIES         number of entries, power of two, 2..256
//   IDXW            index width, derived from ENTRIES (not overridable)
//
// Ports
//   CLK             clock
//   nRST            asynchronous active-low reset
//   fetch_pc        PC being fetched (word aligned, bits [1:0] ignored)
//   hit             valid entry with matching tag for fetch_pc
//   baddr           stored target on hit, else 0
//   pred_state      stored counter on hit, else 2'b01
//   upd_en          resolved branch presented this cycle
//   upd_pc          PC of the resolved branch
//   upd_target      computed branch target
//   upd_taken       actual direction
//   upd_pred_taken  direction predicted for this branch
//   flush           invalidate all entries at the next edge
//   mispredict      upd_en & (upd_taken != upd_pred_taken), combinational
//   hit_cnt         cycles with hit = 1 (wraps)
//   mispred_cnt     cycles with mispredict = 1 (wraps)
//
// Build option
//   BTB_BYPASS_EN   when defined, an update to the same PC as the current
//                   fetch is forwarded to the lookup outputs in that cycle.
//
// Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
// ---------------------------------------------------------------------------
module branch_target_buffer #(
    parameter  int ENTRIES = 16,
    localparam int IDXW    = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        hit,
    output logic [31:0] baddr,
    output logic [1:0]  pred_state,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    input  logic        flush,
    output logic        mispredict,
    output logic [31:0] hit_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int TAGW = 30 - IDXW;

    logic              valid_q  [ENTRIES];
    logic [TAGW-1:0]   tag_q    [ENTRIES];
    logic [31:0]       target_q [ENTRIES];
    logic [1:0]        ctr_q    [ENTRIES];

    logic [IDXW-1:0]   f_idx;
    logic [TAGW-1:0]   f_tag;
    logic [IDXW-1:0]   u_idx;
    logic [TAGW-1:0]   u_tag;

    logic              arr_hit;
    logic              u_hit;
    logic              u_wr;
    logic [1:0]        new_ctr;
    logic [31:0]       new_target;

    // Byte-offset bits of the PCs carry no information for word-aligned fetch.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

    assign f_idx = fetch_pc[IDXW+1:2];
    assign f_tag = fetch_pc[31:IDXW+2];
    assign u_idx = upd_pc[IDXW+1:2];
    assign u_tag = upd_pc[31:IDXW+2];

    assign arr_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    assign mispredict = upd_en && (upd_taken != upd_pred_taken);

    // Post-update contents of the entry selected by upd_pc. A miss that is
    // not taken leaves the array alone; flush discards the update entirely.
    always_comb begin
        u_wr       = upd_en && !flush && (u_hit || upd_taken);
        new_ctr    = 2'b10;
        new_target = upd_target;
        if (u_hit) begin
            if (upd_taken) begin
                new_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
                new_target = upd_target;
            end else begin
                new_ctr    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
                new_target = target_q[u_idx];
            end
        end
    end

    always_comb begin
        hit        = arr_hit;
        baddr      = arr_hit ? target_q[f_idx] : 32'h0;
        pred_state = arr_hit ? ctr_q[f_idx]    : 2'b01;
`ifdef BTB_BYPASS_EN
        // Index and tag both equal means the full word address is equal.
        if (u_wr && (u_idx == f_idx) && (u_tag == f_tag)) begin
            hit        = 1'b1;
            baddr      = new_target;
            pred_state = new_ctr;
        end
`endif
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= 2'b01;
            end
        end else if (flush) begin
            // Only the valid bits are cleared; stale targets/counters are harmless.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (u_wr) begin
            valid_q[u_idx]  <= 1'b1;
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= new_target;
            ctr_q[u_idx]    <= new_ctr;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_cnt     <= 32'h0;
            mispred_cnt <= 32'h0;
        end else begin
            if (hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (mispredict) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int N = 16;

    logic        CLK;
    logic        nRST;
    logic [31:0] fetch_pc;
    logic        hit;
    logic [31:0] baddr;
    logic [1:0]  pred_state;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic        flush;
    logic        mispredict;
    logic [31:0] hit_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc),
        .hit(hit), .baddr(baddr), .pred_state(pred_state),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
        .flush(flush), .mispredict(mispredict),
        .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    logic [31:0] m_hits;
    logic [31:0] m_mis;

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_hits = 0; m_mis = 0;
    endfunction

    function automatic void m_compute(input logic [31:0] pc, input logic [31:0] tgt, input bit tk,
                                      output bit wr, output int nctr, output logic [31:0] ntgt);
        int i;
        bit h;
        i = int'((pc / 4) % N);
        h = m_valid[i] && (m_tag[i] == pc / (4 * N));
        wr = h || tk;
        if (h) begin
            if (tk) nctr = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else    nctr = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            ntgt = tk ? tgt : m_tgt[i];
        end else begin
            nctr = 2;
            ntgt = tgt;
        end
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, input bit ue, input logic [31:0] upc,
                                     input logic [31:0] tgt, input bit tk, input bit fl,
                                     output bit h, output logic [31:0] a, output logic [1:0] p);
        int i;
        bit wr;
        int nctr;
        logic [31:0] ntgt;
        i = int'((pc / 4) % N);
        if (m_valid[i] && m_tag[i] == pc / (4 * N)) begin
            h = 1; a = m_tgt[i]; p = 2'(m_ctr[i]);
        end else begin
            h = 0; a = 0; p = 2'b01;
        end
        m_compute(upc, tgt, tk, wr, nctr, ntgt);
`ifdef BTB_BYPASS_EN
        if (ue && !fl && (pc / 4) == (upc / 4) && wr) begin
            h = 1; a = ntgt; p = 2'(nctr);
        end
`else
        if (ue && fl && wr && (pc == 32'hFFFF_FFFF)) h = h; // keeps unused-arg lint quiet in this build
`endif
    endfunction

    function automatic void m_update(input bit ue, input logic [31:0] upc, input logic [31:0] tgt,
                                     input bit tk, input bit fl);
        bit wr;
        int nctr;
        logic [31:0] ntgt;
        int i;
        if (fl) begin
            for (int k = 0; k < N; k++) m_valid[k] = 0;
        end else if (ue) begin
            m_compute(upc, tgt, tk, wr, nctr, ntgt);
            if (wr) begin
                i = int'((upc / 4) % N);
                m_valid[i] = 1; m_tag[i] = upc / (4 * N); m_tgt[i] = ntgt; m_ctr[i] = nctr;
            end
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle, check lookup/statistics before the edge, then advance.
    task automatic cycle(input bit ue, input logic [31:0] upc, input logic [31:0] utgt,
                         input bit utk, input bit upt, input bit fl, input logic [31:0] fpc,
                         input bit use_exp, input bit eh, input logic [31:0] ea,
                         input logic [1:0] ep, input string nm);
        bit h;
        logic [31:0] a;
        logic [1:0] p;
        upd_en = ue; upd_pc = upc; upd_target = utgt; upd_taken = utk;
        upd_pred_taken = upt; flush = fl; fetch_pc = fpc;
        #4;
        m_lookup(fpc, ue, upc, utgt, utk, fl, h, a, p);
        chk({nm, "_hit"}, {31'b0, hit}, {31'b0, h});
        chk({nm, "_baddr"}, baddr, a);
        chk({nm, "_pred"}, {30'b0, pred_state}, {30'b0, p});
        chk({nm, "_mispredict"}, {31'b0, mispredict}, {31'b0, ue && (utk != upt)});
        chk({nm, "_hit_cnt"}, hit_cnt, m_hits);
        chk({nm, "_mispred_cnt"}, mispred_cnt, m_mis);
        if (use_exp) begin
            chk({nm, "_tab_hit"}, {31'b0, hit}, {31'b0, eh});
            chk({nm, "_tab_baddr"}, baddr, ea);
            chk({nm, "_tab_pred"}, {30'b0, pred_state}, {30'b0, ep});
        end
        @(posedge CLK);
        m_update(ue, upc, utgt, utk, fl);
        if (h) m_hits = m_hits + 1;
        if (ue && (utk != upt)) m_mis = m_mis + 1;
        #1;
    endtask

    typedef struct {
        bit          ue;
        logic [31:0] upc;
        logic [31:0] utgt;
        bit          utk;
        bit          upt;
        bit          fl;
        logic [31:0] fpc;
        bit          eh;
        logic [31:0] ea;
        logic [1:0]  ep;
    } vec_t;

    vec_t vt[28];

    function automatic vec_t mk(input bit ue, input logic [31:0] upc, input logic [31:0] utgt,
                                input bit utk, input bit upt, input bit fl, input logic [31:0] fpc,
                                input bit eh, input logic [31:0] ea, input logic [1:0] ep);
        vec_t v;
        v.ue = ue; v.upc = upc; v.utgt = utgt; v.utk = utk; v.upt = upt; v.fl = fl;
        v.fpc = fpc; v.eh = eh; v.ea = ea; v.ep = ep;
        return v;
    endfunction

    function automatic logic [31:0] pool_pc();
        logic [31:0] t, i, lo;
        t  = $urandom_range(0, 5);
        i  = $urandom_range(0, 3);
        lo = $urandom_range(0, 3);
        return (t << 6) | (i << 2) | lo;
    endfunction

    initial begin
        vt[0]  = mk(0, 0,      0,      0, 0, 0, 32'h100, 0, 0,      2'b01);
        vt[1]  = mk(1, 32'h100, 32'h200, 1, 0, 0, 32'h000, 0, 0,    2'b01);
        vt[2]  = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b10);
        vt[3]  = mk(1, 32'h100, 32'h200, 1, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[4]  = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b11);
        vt[5]  = mk(1, 32'h100, 32'h200, 1, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[6]  = mk(1, 32'h100, 32'h200, 1, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[7]  = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b11);
        vt[8]  = mk(1, 32'h100, 32'h999, 0, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[9]  = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b10);
        vt[10] = mk(1, 32'h100, 32'h999, 0, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[11] = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b01);
        vt[12] = mk(1, 32'h100, 32'h999, 0, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[13] = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b00);
        vt[14] = mk(1, 32'h100, 32'h999, 0, 0, 0, 32'h104, 0, 0,    2'b01);
        vt[15] = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h200, 2'b00);
        vt[16] = mk(1, 32'h140, 32'h300, 1, 1, 0, 32'h104, 0, 0,    2'b01);
        vt[17] = mk(0, 0,      0,      0, 0, 0, 32'h100, 0, 0,      2'b01);
        vt[18] = mk(0, 0,      0,      0, 0, 0, 32'h140, 1, 32'h300, 2'b10);
        vt[19] = mk(1, 32'h180, 32'h500, 0, 0, 0, 32'h104, 0, 0,    2'b01);
        vt[20] = mk(0, 0,      0,      0, 0, 0, 32'h180, 0, 0,      2'b01);
        vt[21] = mk(0, 0,      0,      0, 0, 0, 32'h140, 1, 32'h300, 2'b10);
        vt[22] = mk(1, 32'h104, 32'h600, 1, 0, 1, 32'h140, 1, 32'h300, 2'b10);
        vt[23] = mk(0, 0,      0,      0, 0, 0, 32'h140, 0, 0,      2'b01);
        vt[24] = mk(0, 0,      0,      0, 0, 0, 32'h104, 0, 0,      2'b01);
        vt[25] = mk(1, 32'h100, 32'h200, 1, 1, 0, 32'h104, 0, 0,    2'b01);
`ifdef BTB_BYPASS_EN
        vt[26] = mk(1, 32'h100, 32'h240, 1, 1, 0, 32'h100, 1, 32'h240, 2'b11);
`else
        vt[26] = mk(1, 32'h100, 32'h240, 1, 1, 0, 32'h100, 1, 32'h200, 2'b10);
`endif
        vt[27] = mk(0, 0,      0,      0, 0, 0, 32'h100, 1, 32'h240, 2'b11);

        nRST = 1'b0;
        upd_en = 0; upd_pc = 0; upd_target = 0; upd_taken = 0; upd_pred_taken = 0;
        flush = 0; fetch_pc = 32'h100;
        m_reset();
        #12;
        chk("reset_hit", {31'b0, hit}, 32'd0);
        chk("reset_baddr", baddr, 32'd0);
        chk("reset_pred", {30'b0, pred_state}, 32'd1);
        chk("reset_hit_cnt", hit_cnt, 32'd0);
        chk("reset_mispred_cnt", mispred_cnt, 32'd0);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        for (int k = 0; k < 28; k++) begin
            cycle(vt[k].ue, vt[k].upc, vt[k].utgt, vt[k].utk, vt[k].upt, vt[k].fl, vt[k].fpc,
                  1, vt[k].eh, vt[k].ea, vt[k].ep, $sformatf("vec%0d", k));
        end
        // Two further hits (rows 18/21 region already counted) – check totals explicitly.
        chk("tab_mispred_total", mispred_cnt, m_mis);
        chk("tab_hit_total", hit_cnt, m_hits);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] upc, fpc;
            upc = pool_pc();
            fpc = ($urandom_range(0, 1) == 1) ? upc : pool_pc();
            cycle($urandom_range(0, 1) == 1, upc, $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, fpc, 0, 0, 0, 2'b00, $sformatf("rnd%0d", k));
        end

        // Make sure 0x100 is present, then reset in the middle of an update.
        cycle(1, 32'h100, 32'h700, 1, 1, 0, 32'h104, 0, 0, 0, 2'b00, "pre_rst");
        upd_en = 1; upd_pc = 32'h3C0; upd_target = 32'h800; upd_taken = 1;
        upd_pred_taken = 0; flush = 0; fetch_pc = 32'h100;
        #2;
        nRST = 1'b0;
        #1;
        chk("midrst_hit", {31'b0, hit}, 32'd0);
        chk("midrst_baddr", baddr, 32'd0);
        chk("midrst_pred", {30'b0, pred_state}, 32'd1);
        chk("midrst_hit_cnt", hit_cnt, 32'd0);
        chk("midrst_mispred_cnt", mispred_cnt, 32'd0);
        chk("midrst_mispredict", {31'b0, mispredict}, 32'd1);
        @(posedge CLK);
        @(negedge CLK);
        upd_en = 0;
        nRST = 1'b1;
        m_reset();
        @(posedge CLK);
        #1;
        cycle(0, 0, 0, 0, 0, 0, 32'h3C0, 1, 0, 0, 2'b01, "post_rst_3c0");
        cycle(0, 0, 0, 0, 0, 0, 32'h100, 1, 0, 0, 2'b01, "post_rst_100");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
